// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// the FSM state encoding and the default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    DONE = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_arb_fsm.sv
// Grant and sequencing FSM for mem_arbiter: data port has strict priority,
// one access in flight at a time, one-cycle DONE that pulses the served valid.
module mem_arb_fsm
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic if_req,
  input  logic dm_req,
  input  logic dm_wr,
  input  logic mem_rvalid,
  output logic grant,
  output logic grant_dm,
  output logic grant_wr,
  output logic rdata_load,
  output logic if_valid,
  output logic dm_valid
);

  arb_state_e state_q, state_d;
  logic       served_dm_q, served_dm_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      served_dm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      served_dm_q <= served_dm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    served_dm_d = served_dm_q;
    grant       = 1'b0;
    grant_dm    = 1'b0;
    grant_wr    = 1'b0;
    rdata_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_req) begin
          grant       = 1'b1;
          grant_dm    = 1'b1;
          grant_wr    = dm_wr;
          served_dm_d = 1'b1;
          state_d     = dm_wr ? D_WR : D_RD;
        end else if (if_req) begin
          grant       = 1'b1;
          served_dm_d = 1'b0;
          state_d     = I_RD;
        end
      end
      I_RD, D_RD: begin
        // Return strobe is only meaningful while a read is outstanding.
        if (mem_rvalid) begin
          rdata_load = 1'b1;
          state_d    = DONE;
        end
      end
      D_WR:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_valid = (state_q == DONE) && !served_dm_q;
  assign dm_valid = (state_q == DONE) &&  served_dm_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single main-memory port.
// Holds the registered memory command and the shared read-data register.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              if_valid,
  output logic              dm_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid
);

  logic grant, grant_dm, grant_wr, rdata_load;

  logic              mem_en_q,    mem_en_d;
  logic              mem_wr_q,    mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;

  mem_arb_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .dm_req     (dm_req),
    .dm_wr      (dm_wr),
    .mem_rvalid (mem_rvalid),
    .grant      (grant),
    .grant_dm   (grant_dm),
    .grant_wr   (grant_wr),
    .rdata_load (rdata_load),
    .if_valid   (if_valid),
    .dm_valid   (dm_valid)
  );

  // Command is launched on the grant edge, so mem_en covers only the first access cycle.
  always_comb begin
    mem_en_d    = grant;
    mem_wr_d    = grant_wr;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if (grant) mem_addr_d = grant_dm ? dm_addr : if_addr;
    if (grant_dm) mem_wdata_d = dm_wdata;
    if (rdata_load) rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; the memory model answers reads
// four cycles after mem_en.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic        if_stall, dm_stall, if_valid, dm_valid;
  logic [15:0] rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          cyc;
  } cmd_t;

  typedef struct {
    bit          is_dm;
    logic [15:0] data;
    bit          chk_data;
    int          cyc;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  logic [15:0] mem_model [logic [15:0]];
  logic        inject_rv = 1'b0;
  logic [15:0] inject_data = 16'h0;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .dm_req     (dm_req),
    .dm_wr      (dm_wr),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .if_stall   (if_stall),
    .dm_stall   (dm_stall),
    .if_valid   (if_valid),
    .dm_valid   (dm_valid),
    .rdata      (rdata),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: single outstanding read, answered 4 cycles after mem_en.
  logic        rv_pend = 1'b0;
  int          rv_due = 0;
  logic [15:0] rv_data = 16'h0;
  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = 16'h0;
  end
  always @(negedge clk) begin
    if (mem_en && !mem_wr) begin
      rv_due  = cyc + 4;
      rv_data = mem_model[mem_addr];
      rv_pend = 1'b1;
    end
    if (inject_rv) begin
      mem_rvalid = 1'b1;
      mem_rdata  = inject_data;
    end else if (rv_pend && cyc == rv_due) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rv_data;
      rv_pend    = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the requester's valid, optionally checking stall, then release req.
  task automatic wait_done(input bit is_dm, input bit chk_stall, input bit drop);
    bit seen = 1'b0;
    bit stall_bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (is_dm ? dm_valid : if_valid) begin
        seen = 1'b1;
        if (chk_stall) chk(is_dm ? "dm_stall_at_valid" : "if_stall_at_valid",
                           32'(is_dm ? dm_stall : if_stall), 32'd0);
        break;
      end
      if (chk_stall && !(is_dm ? dm_stall : if_stall)) stall_bad = 1'b1;
    end
    chk(is_dm ? "dm_valid_timeout" : "if_valid_timeout", 32'(seen), 32'd1);
    if (chk_stall) chk(is_dm ? "dm_stall_while_waiting" : "if_stall_while_waiting",
                       32'(stall_bad), 32'd0);
    if (drop) begin
      step();
      if (is_dm) dm_req = 1'b0;
      else       if_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    resp_t r;
    cmd_t  c;
    rst_n = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_wr = 1'b0;
    if_addr = 16'h0; dm_addr = 16'h0; dm_wdata = 16'h0;
    mem_model[16'h0010] = 16'hA5A5;
    mem_model[16'h0300] = 16'h5A5A;
    mem_model[16'h0040] = 16'hBEEF;
    mem_model[16'h0020] = 16'h1111;
    mem_model[16'h0030] = 16'h2222;
    mem_model[16'h0400] = 16'h3333;

    repeat (3) @(negedge clk);
    chk("rst_mem_en",    32'(mem_en),    32'd0);
    chk("rst_mem_wr",    32'(mem_wr),    32'd0);
    chk("rst_if_valid",  32'(if_valid),  32'd0);
    chk("rst_dm_valid",  32'(dm_valid),  32'd0);
    chk("rst_rdata",     32'(rdata),     32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    step();
    rst_n = 1'b1;

    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (if_valid || dm_valid) begin
            if (resp_q.size() == 0) begin
              chk("unexpected_valid", 32'({dm_valid, if_valid}), 32'd0);
            end else begin
              r = resp_q.pop_front();
              chk("valid_who", 32'({dm_valid, if_valid}), r.is_dm ? 32'd2 : 32'd1);
              chk("valid_cycle", 32'(cyc), 32'(r.cyc));
              if (r.chk_data) chk("rdata", 32'(rdata), 32'(r.data));
            end
          end
          if (mem_en) begin
            if (cmd_q.size() == 0) begin
              chk("unexpected_mem_en", 32'(mem_en), 32'd0);
            end else begin
              c = cmd_q.pop_front();
              chk("mem_wr", 32'(mem_wr), 32'(c.wr));
              chk("mem_addr", 32'(mem_addr), 32'(c.addr));
              chk("mem_en_cycle", 32'(cyc), 32'(c.cyc));
              if (c.wr) chk("mem_wdata", 32'(mem_wdata), 32'(c.wdata));
            end
          end
        end
      end
      begin : stimulus
        // Fetch read 0x0010 -> 0xA5A5
        step(); c0 = cyc;
        cmd_q.push_back('{1'b0, 16'h0010, 16'h0, c0 + 1});
        resp_q.push_back('{1'b0, 16'hA5A5, 1'b1, c0 + 6});
        if_addr = 16'h0010; if_req = 1'b1;
        wait_done(1'b0, 1'b1, 1'b1);
        repeat (2) step();

        // Data write 0x0200 <= 0x1234
        c0 = cyc;
        cmd_q.push_back('{1'b1, 16'h0200, 16'h1234, c0 + 1});
        resp_q.push_back('{1'b1, 16'h0, 1'b0, c0 + 2});
        dm_addr = 16'h0200; dm_wdata = 16'h1234; dm_wr = 1'b1; dm_req = 1'b1;
        wait_done(1'b1, 1'b1, 1'b1);
        dm_wr = 1'b0;
        repeat (2) step();

        // Simultaneous data read 0x0300 and fetch 0x0040
        c0 = cyc;
        cmd_q.push_back('{1'b0, 16'h0300, 16'h0, c0 + 1});
        cmd_q.push_back('{1'b0, 16'h0040, 16'h0, c0 + 8});
        resp_q.push_back('{1'b1, 16'h5A5A, 1'b1, c0 + 6});
        resp_q.push_back('{1'b0, 16'hBEEF, 1'b1, c0 + 13});
        dm_addr = 16'h0300; dm_wr = 1'b0; if_addr = 16'h0040;
        dm_req = 1'b1; if_req = 1'b1;
        fork
          wait_done(1'b1, 1'b1, 1'b1);
          wait_done(1'b0, 1'b1, 1'b1);
        join
        repeat (2) step();

        // Reset in the cycle after mem_en of a fetch: abandoned, stray rvalid ignored
        c0 = cyc;
        cmd_q.push_back('{1'b0, 16'h0020, 16'h0, c0 + 1});
        if_addr = 16'h0020; if_req = 1'b1;
        step(); step();
        rst_n = 1'b0; if_req = 1'b0;
        @(negedge clk);
        chk("midrst_mem_en", 32'(mem_en), 32'd0);
        chk("midrst_rdata",  32'(rdata),  32'd0);
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("stray_rvalid_rdata", 32'(rdata), 32'd0);

        // Normal fetch after the reset
        c0 = cyc;
        cmd_q.push_back('{1'b0, 16'h0030, 16'h0, c0 + 1});
        resp_q.push_back('{1'b0, 16'h2222, 1'b1, c0 + 6});
        if_addr = 16'h0030; if_req = 1'b1;
        wait_done(1'b0, 1'b1, 1'b1);
        repeat (2) step();

        // Data read with dm_req dropped in cycle 2: completes once, no re-issue
        c0 = cyc;
        cmd_q.push_back('{1'b0, 16'h0400, 16'h0, c0 + 1});
        resp_q.push_back('{1'b1, 16'h3333, 1'b1, c0 + 6});
        dm_addr = 16'h0400; dm_wr = 1'b0; dm_req = 1'b1;
        step(); step();
        dm_req = 1'b0;
        wait_done(1'b1, 1'b0, 1'b0);
        repeat (6) step();

        // mem_rvalid while IDLE must be ignored
        inject_data = 16'hDEAD; inject_rv = 1'b1;
        step();
        inject_rv = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("idle_rvalid_rdata", 32'(rdata), 32'h3333);

        repeat (2) step();
        chk("cmd_q_empty",  32'(cmd_q.size()),  32'd0);
        chk("resp_q_empty", 32'(resp_q.size()), 32'd0);
      end
    join_any
    disable fork;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port if_req, input, 1, instruction-fetch read request, held until if_valid.
REQ-006 SHALL have port if_addr, input, ADDR_W, fetch address.
REQ-007 SHALL have port dm_req, input, 1, data-memory request from the MEM stage, held until dm_valid.
REQ-008 SHALL have port dm_wr, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have ports dm_addr (input, ADDR_W) and dm_wdata (input, DATA_W), data access address and write data.
REQ-010 SHALL have ports if_stall and dm_stall, output, 1 each, requester stall.
REQ-011 SHALL have ports if_valid and dm_valid, output, 1 each, one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, DATA_W, read data, shared by both requesters.
REQ-013 SHALL have ports mem_en, mem_wr (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W), all registered, forming the main-memory command.
REQ-014 SHALL have ports mem_rdata (input, DATA_W) and mem_rvalid (input, 1), the main-memory read return.

Function
REQ-015 SHALL implement states IDLE, I_RD, D_RD, D_WR and DONE.
REQ-016 In IDLE the arbiter SHALL grant dm_req ahead of if_req (strict data priority); with both high it SHALL serve data, then fetch.
REQ-017 On a grant the arbiter SHALL capture the address (and dm_wdata) and go to I_RD, D_RD or D_WR.
REQ-018 mem_en SHALL be high for exactly the first cycle of I_RD, D_RD or D_WR; mem_wr SHALL be high only in D_WR.
REQ-019 In I_RD or D_RD the arbiter SHALL wait for mem_rvalid, register mem_rdata into rdata on that edge, then enter DONE.
REQ-020 D_WR SHALL last one cycle and then enter DONE (write-through: no read-back).
REQ-021 DONE SHALL last one cycle, pulse the served requester's valid, accept no new request, and return to IDLE.
REQ-022 if_stall SHALL equal if_req & ~if_valid; dm_stall SHALL equal dm_req & ~dm_valid (combinational).
REQ-023 Minimum latency SHALL be: write, request cycle 0 -> dm_valid in cycle 2; read, rvalid in cycle N -> valid in cycle N+1.
REQ-024 mem_rvalid outside I_RD and D_RD SHALL be ignored.
REQ-025 Deassertion of a request mid-access SHALL NOT abort it; the valid pulse still occurs.
REQ-026 rdata SHALL hold its last value until the next read return.

Reset
REQ-027 While rst_n=0 the arbiter SHALL hold state IDLE with mem_en, mem_wr, if_valid and dm_valid at 0 and rdata, mem_addr and mem_wdata at 0.
REQ-028 Reset mid-access SHALL immediately abandon the access; no valid pulse SHALL follow.

Structure
REQ-029 A shared package mem_arb_pkg SHALL hold the state encoding and the ADDR_W/DATA_W defaults.
REQ-030 The FSM and grant logic MAY live in the sub-module mem_arb_fsm; the command and data registers SHALL stay in mem_arbiter.

Verification
(The bench memory model returns mem_rvalid 4 cycles after mem_en.)
REQ-031 if_req=1, if_addr=0x0010, memory word 0xA5A5 -> mem_en in cycle 1; if_valid in cycle 6 with rdata=0xA5A5; if_stall high in cycles 0-5.
REQ-032 dm_req=1, dm_wr=1, dm_addr=0x0200, dm_wdata=0x1234 -> in cycle 1 mem_en=mem_wr=1 with 0x0200/0x1234; dm_valid in cycle 2.
REQ-033 if_req and dm_req (read, 0x0300) both rise in cycle 0 -> data served first (dm_valid in cycle 6), then fetch issued in cycle 8 (if_valid in cycle 13).
REQ-034 rst_n pulsed low in the cycle after mem_en of a read -> no valid pulse; the later stray mem_rvalid is ignored; the next request is served normally.
REQ-035 dm_req dropped in cycle 2 of a D_RD access -> dm_valid still pulses once; no re-issue follows.
REQ-036 mem_rvalid asserted in IDLE -> no state change, rdata unchanged.
